// File: rtl/dmem_bus_bridge_pkg.sv
// dmem_bus_bridge_pkg: shared state codes, defaults and helpers for the data-memory bus bridge
package dmem_bus_bridge_pkg;
  typedef enum logic [2:0] {
    BRG_IDLE,
    BRG_WR_BUSY,
    BRG_RD_WAIT_WB,
    BRG_RD_REQ,
    BRG_RD_DONE
  } brg_state_t;
  localparam int BRG_TIMEOUT_DEF = 200;
  localparam logic [31:0] BRG_ABORT_DATA = 32'h0000_0000;
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/dmem_bus_bridge_wbuf.sv
// dmem_wbuf: one-entry access register driving the bus address/data/byte-enables
//  clk, rst (async active-low)
//  ld     capture d_* this cycle (any accepted access)
//  wr     captured access is a store (sets full)
//  drain  store finished or aborted (clears full)
//  full   a store is held and not yet retired
//  q_*    registered address/data/byte-enables
module dmem_wbuf (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic        wr,
  input  logic        drain,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data,
  input  logic [3:0]  d_be,
  output logic        full,
  output logic [31:0] q_addr,
  output logic [31:0] q_data,
  output logic [3:0]  q_be
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full   <= 1'b0;
      q_addr <= '0;
      q_data <= '0;
      q_be   <= '0;
    end else begin
      full   <= ld ? wr : (drain ? 1'b0 : full);
      q_addr <= ld ? d_addr : q_addr;
      q_data <= ld ? d_data : q_data;
      q_be   <= ld ? d_be : q_be;
    end
  end
endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: data-side req/ack bus bridge with one-entry posted write buffer
//  clk, rst (async active-low)
//  Zz_addr/Zz_dout/Zz_wr_en/rd_en  access from mem_module; zZ_din load word back
//  stall   combinational pipeline freeze
//  bus_*   registered req/ack bus master; bus_err sticky timeout, err_clr clears it
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT = BRG_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Zz_addr,
  input  logic [31:0] Zz_dout,
  input  logic [3:0]  Zz_wr_en,
  input  logic        rd_en,
  output logic [31:0] zZ_din,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  input  logic        err_clr
);
  brg_state_t state, nxt;
  logic [7:0] cnt;
  logic store, access, accept, hit_to, done, abort, wr_phase, full;
  assign store    = |Zz_wr_en;
  assign access   = store | rd_en;
  assign wr_phase = state == BRG_WR_BUSY || state == BRG_RD_WAIT_WB;
  // a load must never overtake the buffered store, so anything arriving behind it waits
  assign stall    = state == BRG_RD_REQ || (full && access);
  assign accept   = access && !stall;
  assign hit_to   = cnt == 8'(TIMEOUT - 1);
  assign done     = bus_req && (bus_ack || hit_to);
  assign abort    = bus_req && !bus_ack && hit_to;
  dmem_wbuf u_wbuf (
    .clk    (clk),
    .rst    (rst),
    .ld     (accept),
    .wr     (store),
    .drain  (wr_phase && done),
    .d_addr (word_addr(Zz_addr)),
    .d_data (Zz_dout),
    .d_be   (store ? Zz_wr_en : 4'hf),
    .full   (full),
    .q_addr (bus_addr),
    .q_data (bus_wdata),
    .q_be   (bus_be)
  );
  always_comb begin
    nxt = state;
    case (state)
      BRG_IDLE, BRG_RD_DONE:       nxt = !accept ? BRG_IDLE : store ? BRG_WR_BUSY : BRG_RD_REQ;
      BRG_WR_BUSY, BRG_RD_WAIT_WB: nxt = done ? BRG_IDLE : (rd_en && !store) ? BRG_RD_WAIT_WB : BRG_WR_BUSY;
      BRG_RD_REQ:                  nxt = done ? BRG_RD_DONE : BRG_RD_REQ;
      default:                     nxt = BRG_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= BRG_IDLE;
      cnt     <= '0;
      bus_req <= 1'b0;
      bus_we  <= 1'b0;
      bus_err <= 1'b0;
      zZ_din  <= '0;
    end else begin
      state   <= nxt;
      cnt     <= (bus_req && !done) ? cnt + 8'd1 : 8'd0;
      // request derives from the next state so it is a clean flop, not a decode
      bus_req <= nxt == BRG_WR_BUSY || nxt == BRG_RD_WAIT_WB || nxt == BRG_RD_REQ;
      bus_we  <= accept ? store : bus_we;
      bus_err <= abort | (bus_err & ~err_clr);
      zZ_din  <= (state == BRG_RD_REQ && done) ? (bus_ack ? bus_rdata : BRG_ABORT_DATA) : zZ_din;
    end
  end
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: randomized and directed checks of dmem_bus_bridge against a transaction-level model
module tb_dmem_bus_bridge;
  localparam int TMO = 200;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] Zz_addr = '0, Zz_dout = '0, bus_rdata = '0;
  logic [3:0] Zz_wr_en = '0;
  logic rd_en = 1'b0, bus_ack = 1'b0, err_clr = 1'b0;
  logic [31:0] zZ_din, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic stall, bus_req, bus_we, bus_err;
  int total = 0, bad = 0;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } op_t;
  op_t exp_q[$];
  logic wr_if = 0, ld_if = 0, pend_ld = 0, clr_next = 0, err_m = 0, no_ack = 0, acc = 0;
  logic [31:0] last_ld = '0, ld_exp = '0, rd_fix = '0;
  int req_cyc = 0, lat = 0, fix_lat = -1;

  dmem_bus_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .Zz_addr   (Zz_addr),
    .Zz_dout   (Zz_dout),
    .Zz_wr_en  (Zz_wr_en),
    .rd_en     (rd_en),
    .zZ_din    (zZ_din),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // one clock: slave answers the in-flight transfer, the pipeline presents an access
  task automatic cycle(input logic [3:0] be, input logic ld, input logic [31:0] a, input logic [31:0] d, input logic clr);
    logic act, abort, want_stall;
    @(negedge clk);
    if (clr_next) begin
      wr_if = 0;
      ld_if = 0;
      clr_next = 0;
    end
    act = wr_if | ld_if;
    abort = 0;
    bus_ack = 0;
    bus_rdata = rd_fix != 0 ? rd_fix : $urandom;
    if (act) begin
      if (req_cyc == 0) lat = fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 3));
      req_cyc++;
      if (!no_ack && req_cyc == lat + 1) bus_ack = 1;
      else if (req_cyc == TMO) abort = 1;
    end else bus_ack = 1'($urandom_range(0, 1));
    Zz_wr_en = be;
    rd_en = ld;
    Zz_addr = a;
    Zz_dout = d;
    err_clr = clr;
    #1;
    want_stall = ld_if | (wr_if & ((|be) | ld));
    chk("stall", 32'(stall), 32'(want_stall));
    chk("bus_req", 32'(bus_req), 32'(act));
    chk("bus_err", 32'(bus_err), 32'(err_m));
    if (act) begin
      chk("bus_we", 32'(bus_we), 32'(exp_q[0].we));
      chk("bus_addr", bus_addr, exp_q[0].addr);
      chk("bus_be", 32'(bus_be), 32'(exp_q[0].be));
      if (exp_q[0].we) chk("bus_wdata", bus_wdata, exp_q[0].data);
    end
    if (pend_ld && !ld_if) begin
      chk("load_data", zZ_din, ld_exp);
      last_ld = ld_exp;
      pend_ld = 0;
    end else chk("zz_din_hold", zZ_din, last_ld);
    acc = !want_stall && ((|be) || ld);
    if (acc) begin
      exp_q.push_back('{|be, {a[31:2], 2'b00}, (|be) ? be : 4'hf, d});
      if (|be) wr_if = 1;
      else begin
        ld_if = 1;
        pend_ld = 1;
      end
    end
    if (act && (bus_ack || abort)) begin
      if (!exp_q[0].we) ld_exp = bus_ack ? bus_rdata : 32'h0;
      void'(exp_q.pop_front());
      clr_next = 1;
      req_cyc = 0;
    end
    err_m = abort | (err_m & ~clr);
  endtask

  task automatic step(input logic [3:0] be, input logic ld, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    do begin
      cycle(be, ld, a, d, 1'b0);
      n++;
    end while (!acc && n < 2000);
    chk("accept_bound", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n, input logic clr);
    repeat (n) cycle(4'h0, 1'b0, $urandom, $urandom, clr);
  endtask

  task automatic reset_model();
    wr_if = 0;
    ld_if = 0;
    pend_ld = 0;
    clr_next = 0;
    err_m = 0;
    last_ld = '0;
    req_cyc = 0;
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_zz_din", zZ_din, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2, 1'b0);
    // store with 3 wait states
    fix_lat = 3;
    step(4'hf, 1'b0, 32'h0000_0010, 32'h1122_3344);
    idle(6, 1'b0);
    // zero-wait load
    fix_lat = 0;
    rd_fix = 32'hCAFE_F00D;
    step(4'h0, 1'b1, 32'h0000_0020, 32'h0);
    idle(3, 1'b0);
    chk("lw_cafe", zZ_din, 32'hCAFE_F00D);
    rd_fix = '0;
    // byte store then load right behind it
    fix_lat = 5;
    step(4'b0100, 1'b0, 32'h0000_0031, 32'hAAAA_AAAA);
    step(4'h0, 1'b1, 32'h0000_0030, 32'h0);
    idle(10, 1'b0);
    // load timeout, then clear the error
    no_ack = 1;
    step(4'h0, 1'b1, 32'h0000_0040, 32'h0);
    idle(TMO + 2, 1'b0);
    chk("to_zz_din", zZ_din, 32'h0);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    no_ack = 0;
    idle(1, 1'b1);
    idle(2, 1'b0);
    chk("err_cleared", 32'(bus_err), 32'd0);
    // store and load requested together: store only
    fix_lat = 1;
    step(4'b0011, 1'b1, 32'h0000_0050, 32'h5555_5555);
    idle(4, 1'b0);
    // write timeout with err_clr held through the abort cycle
    no_ack = 1;
    step(4'hf, 1'b0, 32'h0000_0060, 32'h6666_6666);
    idle(TMO + 2, 1'b1);
    no_ack = 0;
    idle(2, 1'b0);
    // random traffic
    fix_lat = -1;
    repeat (200) begin
      case ($urandom_range(0, 5))
        0, 1: step(4'($urandom_range(1, 15)), 1'b0, $urandom, $urandom);
        2, 3: step(4'h0, 1'b1, $urandom, $urandom);
        4: step(4'($urandom_range(1, 15)), 1'b1, $urandom, $urandom);
        default: idle(int'($urandom_range(1, 3)), 1'b0);
      endcase
    end
    idle(8, 1'b0);
    rd_fix = 32'h1234_5678;
    step(4'h0, 1'b1, 32'h0000_0074, 32'h0);
    idle(4, 1'b0);
    rd_fix = '0;
    // reset while a read is outstanding
    fix_lat = 8;
    step(4'h0, 1'b1, 32'h0000_0070, 32'h0);
    idle(2, 1'b0);
    @(negedge clk);
    Zz_wr_en = '0;
    rd_en = 1'b0;
    bus_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_zz_din", zZ_din, 32'd0);
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fix_lat = -1;
    idle(2, 1'b0);
    step(4'h0, 1'b1, $urandom, 32'h0);
    step(4'hf, 1'b0, $urandom, $urandom);
    step(4'h0, 1'b1, $urandom, 32'h0);
    idle(8, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
